aes_mix_columns_seq: RTL
========================

Name: aes_mix_columns_seq

Overview:
Iterative AES forward MixColumns engine for the encryption datapath; it is the forward counterpart of the InvMixColumns byte-multiplier LUTs used on the decryption side. It accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the mixed state over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per BUSY cycle; legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a state
in_data  input  128  input state; bits [127:120] = byte 0 (row 0, col 0); column c = bits [127-32c -: 32], top byte = row 0
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts the result
out_data  output  128  mixed state, same byte order as in_data
busy  output  1  high in BUSY and DONE

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. On a clock edge with rst=1: FSM to IDLE, in_ready=1, out_valid=0, busy=0, out_data=128'h0, column counter=0. Reset mid-operation discards the in-flight state with no partial output.
- FSM IDLE: in_ready=1.
  - On an edge with in_valid&in_ready: load the state register from in_data, clear col, go to BUSY.
- FSM BUSY: in_ready=0.
  - Each cycle, columns col..col+COLS_PER_CYCLE-1 are replaced in the state register with their mixed value.
  - col advances by COLS_PER_CYCLE and wraps at 4.
  - After the last column, go to DONE.
  - Number of BUSY cycles = 4/COLS_PER_CYCLE.
- FSM DONE: out_valid=1, out_data = state register.
  - On an edge with out_ready=1: go to IDLE and set out_valid=0.
  - No accept happens in the same cycle, because in_ready=0 in DONE.
- Latency: handshake edge E0; out_valid rises after edge E0+4/COLS_PER_CYCLE (4, 2 or 1 cycles). Throughput = one state per 4/COLS_PER_CYCLE+2 cycles when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid hold stable indefinitely. in_valid is ignored outside IDLE.
- Column math, over GF(2^8) with reduction polynomial 0x11b:
  - s0' = 2s0^3s1^s2^s3
  - s1' = s0^2s1^3s2^s3
  - s2' = s0^s1^2s2^3s3
  - s3' = 3s0^s1^s2^2s3
- Multiplication rules:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - 3a = xtime(a) ^ a.
  - All arithmetic is 8-bit XOR; no carries and no widening.
- in_data is sampled only at the accept edge; later changes to in_data have no effect.
- rst asserted together with in_valid: reset wins and nothing is accepted.

Decomposition:
- Package aes_pkg holds:
  - constant AES_RED_POLY = 8'h1b
  - function xtime(8-bit)
  - typedef aes_state_t (128-bit) and aes_col_t (32-bit)
  - FSM state enum {IDLE, BUSY, DONE}
- Sub-module aes_mix_column: purely combinational, 32-bit column in, 32-bit column out. It is instantiated COLS_PER_CYCLE times.

Test Plan:
- Single column check: columns db135345, f20a225c, 01010101, c6c6c6c6 in one state -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising exactly 4 cycles after accept (COLS_PER_CYCLE=1).
- Second vector: state d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff. Repeat with COLS_PER_CYCLE=2 and 4 and check latency of 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stays stable and in_ready stays 0. Raise out_ready -> out_valid drops next edge and in_ready=1.
- Back-to-back: in_valid held high with 3 distinct states and out_ready=1 -> three correct results in order, accepts spaced 6 cycles apart (COLS_PER_CYCLE=1).
- Reset mid-operation: assert rst for 1 cycle 2 cycles after accept -> no out_valid ever for that state; in_ready=1 and out_data=0 the cycle after reset. A following state is processed correctly.
- Random: 1000 random states with random out_ready stalls -> every result matches a software model built on xtime.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, GF(2^8) helpers and FSM encoding.
// Also holds the column extract/insert helpers used by the iterative engine.
package aes_pkg;

    localparam logic [7:0] AES_RED_POLY = 8'h1b;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_RED_POLY : 8'h00);
    endfunction

    // Column c occupies bits [127-32c -: 32]; column 0 is the most significant word.
    function automatic aes_col_t col_get(input aes_state_t s, input logic [1:0] c);
        aes_col_t v;
        case (c)
            2'd0:    v = s[127:96];
            2'd1:    v = s[95:64];
            2'd2:    v = s[63:32];
            default: v = s[31:0];
        endcase
        return v;
    endfunction

    function automatic aes_state_t col_put(input aes_state_t s, input logic [1:0] c,
                                          input aes_col_t v);
        aes_state_t r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Forward MixColumns on a single 32-bit column (row 0 in the top byte).
// Purely combinational; only xtime and XOR are needed for the {1,2,3} coefficients.
module aes_mix_column
    import aes_pkg::*;
(
    input  aes_col_t i_col,
    output aes_col_t o_col
);

    logic [7:0] w_s0, w_s1, w_s2, w_s3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign w_s0 = i_col[31:24];
    assign w_s1 = i_col[23:16];
    assign w_s2 = i_col[15:8];
    assign w_s3 = i_col[7:0];

    assign w_x0 = xtime(w_s0);
    assign w_x1 = xtime(w_s1);
    assign w_x2 = xtime(w_s2);
    assign w_x3 = xtime(w_s3);

    // 3a is expressed as xtime(a) ^ a.
    assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_s1) ^ w_s2 ^ w_s3;
    assign o_col[23:16] = w_s0 ^ w_x1 ^ (w_x2 ^ w_s2) ^ w_s3;
    assign o_col[15:8]  = w_s0 ^ w_s1 ^ w_x2 ^ (w_x3 ^ w_s3);
    assign o_col[7:0]   = (w_x0 ^ w_s0) ^ w_s1 ^ w_s2 ^ w_x3;

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Iterative forward MixColumns: accept a state, mix COLS_PER_CYCLE columns per
// BUSY cycle in place, then hold the result until the consumer takes it.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    aes_fsm_t   r_fsm;
    aes_state_t r_state;
    logic [1:0] r_col;

    aes_col_t   w_col_in  [COLS_PER_CYCLE];
    aes_col_t   w_col_out [COLS_PER_CYCLE];
    logic [1:0] w_idx     [COLS_PER_CYCLE];
    aes_state_t w_state_mixed;
    logic [2:0] w_col_sum;
    logic       w_last;

    genvar k;
    generate
        for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
            assign w_idx[k]    = r_col + 2'(k);
            assign w_col_in[k] = col_get(r_state, w_idx[k]);
            aes_mix_column u_mix (
                .i_col (w_col_in[k]),
                .o_col (w_col_out[k])
            );
        end
    endgenerate

    always_comb begin
        w_state_mixed = r_state;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_state_mixed = col_put(w_state_mixed, w_idx[j], w_col_out[j]);
        end
    end

    // Carry out of the 2-bit column counter marks the final BUSY cycle.
    assign w_col_sum = {1'b0, r_col} + 3'(COLS_PER_CYCLE);
    assign w_last    = w_col_sum[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_col   <= 2'd0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_col   <= 2'd0;
                        r_fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    r_state <= w_state_mixed;
                    r_col   <= w_col_sum[1:0];
                    if (w_last) r_fsm <= DONE;
                end
                DONE: begin
                    if (out_ready) r_fsm <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == IDLE);
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm == BUSY) || (r_fsm == DONE);
    assign out_data  = r_state;

endmodule
